// File: rtl/sign_narrower.sv
// sign_narrower: streaming 16-to-8 bit signed narrowing with overflow tracking and a 2-entry output buffer
module sign_narrower #(
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_ovf,
  input  logic             clr_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);
  logic [1:0] occ;
  logic [8:0] head, tail;
  logic       ovf, push, pop;
  logic [7:0] res;
  // narrow the incoming word and derive handshake strobes from registered occupancy
  always_comb begin
    ovf = ~(&in_data[15:7] | ~|in_data[15:7]);
    res = (ovf && SATURATE) ? (in_data[15] ? 8'h80 : 8'h7F) : in_data[7:0];
    in_ready = occ != 2'd2;
    out_valid = occ != 2'd0;
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    out_data = out_valid ? head[8:1] : 8'h00;
    out_ovf = out_valid & head[0];
  end
  // two-slot buffer: head is shown at the output, tail waits behind it
  always_ff @(posedge CLK) begin
    if (RST) begin
      occ <= 2'd0;
      head <= 9'd0;
      tail <= 9'd0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (pop) head <= (push && occ == 2'd1) ? {res, ovf} : tail;
      else if (push && occ == 2'd0) head <= {res, ovf};
      if (push && !pop && occ == 2'd1) tail <= {res, ovf};
    end
  end
  // overflow sticky flag and saturating counter; a new overflow beats a clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_sticky <= 1'b0;
      ovf_count <= '0;
    end else if (push && ovf) begin
      ovf_sticky <= 1'b1;
      ovf_count <= clr_ovf ? CNT_W'(1) : (&ovf_count ? ovf_count : ovf_count + CNT_W'(1));
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
      ovf_count <= '0;
    end
  end
endmodule

// File: doc/sign_narrower.md
Name: sign_narrower

Overview:
- Streaming 16-bit to 8-bit signed narrowing unit; the inverse of the datapath's 8-to-16 sign-extension stage.
- Accepts 16-bit two's-complement words over a valid/ready handshake.
- Reduces each word to 8 bits, either saturating or wrapping.
- Flags every word not representable in 8 bits; keeps a sticky overflow flag and a saturating overflow counter.
- Sits between the 16-bit ALU result path and 8-bit consumers (register file byte lanes, byte bus), behind a 2-entry output buffer.

Parameters:
- SATURATE, 1, 1 = clamp out-of-range values to 8'h7F/8'h80; 0 = wrap (keep low byte).
- CNT_W, 8, width of the overflow event counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  16  signed input word.
- out_valid  output  1  head buffer entry valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_data  output  8  narrowed result at the buffer head.
- out_ovf  output  1  head entry was out of 8-bit range.
- clr_ovf  input  1  one-cycle pulse; clears ovf_sticky and ovf_count.
- ovf_sticky  output  1  set by any accepted out-of-range word.
- ovf_count  output  CNT_W  number of accepted out-of-range words, saturating.

Behaviour:
- Range check:
  - fits = 1 when in_data[15:7] are all 0 or all 1; ovf = ~fits.
- Result:
  - fits: in_data[7:0].
  - ovf and SATURATE=1: in_data[15] ? 8'h80 : 8'h7F.
  - ovf and SATURATE=0: in_data[7:0].
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (occupancy < 2), registered-state-derived only; no combinational path from out_ready.
  - out_valid = (occupancy != 0).
  - in_data may change freely while in_valid=0.
- Buffer:
  - 2-entry FIFO of {result, ovf}.
  - out_data/out_ovf show the head entry; both are 0 when empty.
  - Order is preserved.
- Latency: a word pushed at edge N is visible on out_* after edge N when the buffer was empty. The result is computed combinationally at the input and stored.
- Occupancy transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop together, occupancy 1: stays 1; head advances to the new word.
  - At occupancy 2, in_ready=0, so only a pop is possible.
  - At occupancy 0, a pop cannot occur.
- Sticky and counter:
  - On push with ovf=1: ovf_sticky <= 1; ovf_count increments, holding at 2^CNT_W-1.
  - On clr_ovf: ovf_sticky <= 0, ovf_count <= 0.
  - clr_ovf together with an overflowing push: set wins; ovf_sticky=1, ovf_count=1.
  - Popping does not affect sticky or count.
- Reset (RST=1 at an edge):
  - occupancy 0, out_valid 0, out_data 0, out_ovf 0, in_ready 1 after the edge.
  - ovf_sticky 0, ovf_count 0.
  - Reset mid-stream discards buffered entries; a push presented during reset is ignored.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, out_data=0, ovf_sticky=0, ovf_count=0.
- Push 16'hFF85, 16'h007F, 16'h0000 with out_ready=1 -> outputs 8'h85, 8'h7F, 8'h00 one cycle after each push, out_ovf=0 throughout, ovf_count=0.
- SATURATE=1: push 16'h0080, then 16'hFF7F -> 8'h7F ovf=1, then 8'h80 ovf=1; ovf_count=2, ovf_sticky=1. SATURATE=0 with the same words -> 8'h80, 8'h7F, both ovf=1.
- out_ready=0, push three words -> in_ready drops after the second push, the third is held upstream. Raise out_ready -> words emerge in order; in_ready returns the cycle after the first pop.
- Occupancy 1 with simultaneous push and pop for 4 cycles -> occupancy stays 1, every word delivered once, in order.
- CNT_W=2: push 5 overflowing words -> ovf_count saturates at 3. Then clr_ovf together with an overflowing push -> ovf_count=1, ovf_sticky=1. Then assert RST with 2 buffered entries -> out_valid=0 next cycle.
